// File: rtl/demux_stream_pkg.sv
// Shared routing-mode constants for the stream demultiplexer.
package demux_stream_pkg;
  localparam logic [1:0] MODE_SEL   = 2'b00;
  localparam logic [1:0] MODE_BCAST = 2'b01;
  localparam logic [1:0] MODE_RR    = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;
endpackage

// File: rtl/demux_stream_router_if.sv
// Producer-side and consumer-side handshake bundle for the router.
interface demux_stream_router_if #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [SELW-1:0] in_sel;
  logic [1:0]      mode;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic [SELW-1:0] rr_ptr;
  logic            drop_pulse;

  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, drop_pulse
  );

  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, drop_pulse
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register; a full slot drained this cycle may reload.
module demux_out_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         can_acc
);
  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign can_acc   = !r_valid || out_ready;
endmodule

// File: rtl/demux_stream_router.sv
// 1-to-N registered stream demux: select, broadcast and round-robin
// routing with drop reporting for out-of-range and reserved beats.
module demux_stream_router
  import demux_stream_pkg::*;
#(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic clk,
  input  logic rst_n,
  demux_stream_router_if.slave bus
);
  localparam int P = 2 ** SELW;
  localparam logic [SELW:0]   NL   = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [N-1:0]    w_can;
  logic [N-1:0]    w_valid;
  logic [N-1:0]    w_load;
  logic [N*W-1:0]  w_data;
  logic [P-1:0]    w_can_p;
  logic [P-1:0]    w_ld_p;
  logic            w_ready;
  logic            w_drop;
  logic            w_adv;
  logic [SELW-1:0] r_rr;
  logic            r_drop;

  // Index through power-of-two padded vectors so any in_sel is legal.
  always_comb begin
    w_can_p          = '0;
    w_can_p[N-1:0]   = w_can;
    w_ld_p           = '0;
    w_ready          = 1'b0;
    w_drop           = 1'b0;
    w_adv            = 1'b0;
    unique case (1'b1)
      (bus.mode == MODE_SEL): begin
        if ({1'b0, bus.in_sel} < NL) begin
          w_ready = w_can_p[bus.in_sel];
          w_ld_p[bus.in_sel] = bus.in_valid && w_ready;
        end else begin
          w_ready = 1'b1;
          w_drop  = bus.in_valid;
        end
      end
      (bus.mode == MODE_BCAST): begin
        w_ready = &w_can;
        w_ld_p  = {P{bus.in_valid && w_ready}};
      end
      (bus.mode == MODE_RR): begin
        w_ready = w_can_p[r_rr];
        w_ld_p[r_rr] = bus.in_valid && w_ready;
        w_adv   = bus.in_valid && w_ready;
      end
      default: begin
        w_ready = 1'b1;
        w_drop  = bus.in_valid;
      end
    endcase
  end

  assign w_load = w_ld_p[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr   <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_adv) r_rr <= (r_rr == LAST) ? '0 : r_rr + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    demux_out_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[i]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[i]),
      .out_valid (w_valid[i]),
      .out_data  (w_data[i*W +: W]),
      .can_acc   (w_can[i])
    );
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_data;
  assign bus.rr_ptr     = r_rr;
  assign bus.drop_pulse = r_drop;
endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Registered, parametrised 1-to-N stream demultiplexer with per-channel valid/ready handshake and a one-entry output register per channel.
- Supports select, broadcast and round-robin routing modes, with out-of-range/reserved-mode drop detection.
- Sits between a single producer (ALU result / operand stream) and N consumer datapaths; successor to the fixed 4-way 16-bit combinational demux.

Parameters:
- W, 16, data width in bits.
- N, 4, number of output channels (2..16; need not be a power of two).
- SELW, 2, width of in_sel; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  W  input payload.
- in_sel  input  SELW  destination channel (select mode only).
- mode  input  2  00 select, 01 broadcast, 10 round-robin, 11 reserved.
- out_valid  output  N  per-channel valid.
- out_ready  input  N  per-channel ready.
- out_data  output  N*W  channel i payload at bits [i*W +: W].
- rr_ptr  output  SELW  current round-robin target channel.
- drop_pulse  output  1  one-cycle pulse: an accepted beat was discarded.

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n. Reset values: out_valid=0, out_data=0, rr_ptr=0, drop_pulse=0.
- Channel i free: can_acc[i] = !out_valid[i] || out_ready[i]. A full slot that is drained in the same cycle accepts a new beat, giving full throughput.
- in_ready is combinational from mode, in_sel, rr_ptr, can_acc and out_ready. It never depends on in_valid.
- Select mode (00):
  - If in_sel < N, in_ready = can_acc[in_sel].
  - If in_sel >= N, in_ready = 1; the beat is dropped and drop_pulse asserts next cycle.
- Broadcast mode (01):
  - in_ready = &can_acc.
  - An accepted beat loads every slot in the same cycle; slots are never partially written.
- Round-robin mode (10):
  - in_ready = can_acc[rr_ptr].
  - Each accepted beat advances rr_ptr by 1, wrapping from N-1 to 0.
  - rr_ptr changes only on an accepted round-robin beat and holds in all other modes.
- Reserved mode (11): in_ready = 1; the beat is dropped and drop_pulse asserts next cycle.
- Latency: a beat accepted at edge k has out_valid/out_data updated at edge k; it is visible for the cycle after k (1-cycle latency).
- Slot update per channel, evaluated each edge:
  - load if written this cycle: out_valid=1, out_data=in_data;
  - else clear out_valid if out_ready[i];
  - else hold.
- out_data holds its last value after out_valid falls; it is not zeroed.
- Mode and in_sel are sampled only on the accepting edge. Changing mode while slots are full affects only subsequent beats.
- drop_pulse is registered, high for exactly one cycle per dropped beat. Back-to-back drops hold it high for consecutive cycles.
- Reset asserted mid-transfer empties all slots immediately; in-flight data is lost.

Decomposition:
- Shared package, demux_stream_pkg: mode constants MODE_SEL=2'b00, MODE_BCAST=2'b01, MODE_RR=2'b10, MODE_RSVD=2'b11.
- One sub-module, demux_out_slot (parameter W): one-entry valid/data register.
  - Inputs: clk, rst_n, load, load_data, out_ready.
  - Outputs: out_valid, out_data, can_acc.
- The top level instantiates N slots through a generate loop and contains the routing logic, rr_ptr counter and drop logic.

Test Plan:
- Select: reset; mode=00; drive in_sel=2, in_data=16'hA5A5 for one cycle; all out_ready=1. Expect in_ready=1; out_valid=4'b0100 with out_data[47:32]=16'hA5A5 for exactly one cycle; other channels stay 0.
- Backpressure: mode=00, out_ready[1]=0. Send two beats to channel 1 (16'h0001, 16'h0002). Expect first beat accepted, in_ready=0 on second. Raise out_ready[1]; expect 16'h0001 consumed and 16'h0002 loaded on the same edge.
- Broadcast: mode=01, out_ready=4'b1110, slot 0 full. Expect in_ready=0 with no slot written. Set out_ready[0]=1; beat 16'hBEEF accepted; out_valid=4'b1111 with all channels showing 16'hBEEF.
- Round-robin wrap: mode=10, all ready, 6 beats 16'h0010..16'h0015 with N=4. Expect them on channels 0,1,2,3,0,1; rr_ptr ends at 2.
- Drop: N=3, SELW=2, mode=00, in_sel=3 with in_valid=1 for one cycle. Expect in_ready=1, no out_valid, drop_pulse=1 for one cycle. Repeat with mode=11; expect the same response.
- Async reset: with slots full and rr_ptr=3, pulse rst_n low mid-cycle. Expect out_valid=0 and rr_ptr=0 immediately, before the next clk edge; normal operation resumes after release.
